// File: rtl/irq_rr_scheduler.sv
// irq_rr_scheduler
// Shares one IRQ request channel between CPU_NB CPUs in round-robin order.
// Each CPU's IRQ vector is watched for changes. The most recent changed value is
// held in a one-deep buffer until that CPU is granted the channel.
// Responses coming back on the channel are routed straight to the per-CPU o_irq
// outputs. Each CPU may issue at most TRANSACTION_NB requests, and o_done latches
// once every CPU has used its full budget and the channel is idle.
module irq_rr_scheduler #(
  parameter int CPU_NB         = 4,
  parameter int TRANSACTION_NB = 1000,
  parameter int IRQ_W          = 32,
  localparam int CPU_W         = (CPU_NB > 1) ? $clog2(CPU_NB) : 1,
  localparam int CNT_W         = $clog2(TRANSACTION_NB + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CPU_NB-1:0][IRQ_W-1:0]    i_irq,
  output logic [CPU_NB-1:0][IRQ_W-1:0]    o_irq,
  output logic                            o_req_valid,
  output logic [CPU_W-1:0]                o_req_cpu,
  output logic [IRQ_W-1:0]                o_req_irq,
  input  logic                            i_req_ready,
  input  logic                            i_resp_valid,
  input  logic [CPU_W-1:0]                i_resp_cpu,
  input  logic [IRQ_W-1:0]                i_resp_irq,
  output logic [CPU_NB-1:0]               o_drop,
  output logic                            o_done
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TRANSACTION_NB);
  localparam logic [CPU_W-1:0] LAST_CPU = CPU_W'(CPU_NB - 1);

  // Per-CPU change tracking and budget state
  logic [CPU_NB-1:0][IRQ_W-1:0] prevQ;
  logic [CPU_NB-1:0][IRQ_W-1:0] valQ, valD;
  logic [CPU_NB-1:0]            pendQ, pendD;
  logic [CPU_NB-1:0]            dropQ, dropD;
  logic [CPU_NB-1:0][CNT_W-1:0] cntQ, cntD;

  // Request channel and arbitration state
  logic [0:0]                   stateQ, stateD;
  logic [CPU_W-1:0]             rrPtrQ, rrPtrD;
  logic                         reqValidQ, reqValidD;
  logic [CPU_W-1:0]             reqCpuQ, reqCpuD;
  logic [IRQ_W-1:0]             reqIrqQ, reqIrqD;

  // Response routing and completion state
  logic [CPU_NB-1:0][IRQ_W-1:0] oIrqQ, oIrqD;
  logic                         doneQ, doneD;

  // Combinational helpers
  logic [CPU_NB-1:0]            underBudget;
  logic [CPU_NB-1:0]            change;
  logic [CPU_NB-1:0]            eligible;
  logic                         grantValid;
  logic [CPU_W-1:0]             grantCpu;
  logic                         respInRange;
  logic                         allAtBudget;

  // A CPU whose counter reached the budget neither registers changes nor competes for grants
  always_comb begin
    underBudget = '0;
    change      = '0;
    eligible    = '0;
    for (int c = 0; c < CPU_NB; c++) begin
      underBudget[c] = (cntQ[c] != CNT_MAX);
      change[c]      = (i_irq[c] != prevQ[c]) && underBudget[c];
      eligible[c]    = pendQ[c] && underBudget[c];
    end
  end

  // Round-robin search for the first eligible CPU starting at rrPtrQ, only while idle
  always_comb begin
    logic [CPU_W:0]   sum;
    logic [CPU_W-1:0] idx;
    sum        = '0;
    idx        = '0;
    grantValid = 1'b0;
    grantCpu   = '0;
    for (int i = 0; i < CPU_NB; i++) begin
      sum = {1'b0, rrPtrQ} + (CPU_W + 1)'(i);
      if (sum >= (CPU_W + 1)'(CPU_NB)) begin
        sum = sum - (CPU_W + 1)'(CPU_NB);
      end
      idx = sum[CPU_W-1:0];
      if (!grantValid && (stateQ == IDLE) && eligible[idx]) begin
        grantValid = 1'b1;
        grantCpu   = idx;
      end
    end
  end

  // Pending-buffer update: a grant empties the buffer, a change refills it.
  // A change landing on the grant edge re-arms the buffer without counting as a drop,
  // since the old value is leaving on the channel rather than being lost.
  always_comb begin
    logic granted;
    granted = 1'b0;
    pendD   = pendQ;
    valD    = valQ;
    dropD   = '0;
    cntD    = cntQ;
    for (int c = 0; c < CPU_NB; c++) begin
      granted = grantValid && (grantCpu == CPU_W'(c));
      if (granted) begin
        pendD[c] = 1'b0;
        if (cntQ[c] != CNT_MAX) begin
          cntD[c] = cntQ[c] + CNT_W'(1);
        end
      end
      if (change[c]) begin
        pendD[c] = 1'b1;
        valD[c]  = i_irq[c];
        dropD[c] = pendQ[c] && !granted;
      end
    end
  end

  // Request FSM: a grant loads the request registers and moves to ISSUE.
  // The FSM holds the request until it is accepted, then returns to IDLE for one bubble cycle.
  always_comb begin
    stateD    = stateQ;
    rrPtrD    = rrPtrQ;
    reqValidD = reqValidQ;
    reqCpuD   = reqCpuQ;
    reqIrqD   = reqIrqQ;
    case (stateQ)
      IDLE: begin
        if (grantValid) begin
          reqValidD = 1'b1;
          reqCpuD   = grantCpu;
          reqIrqD   = valQ[grantCpu];
          rrPtrD    = (grantCpu == LAST_CPU) ? '0 : grantCpu + CPU_W'(1);
          stateD    = ISSUE;
        end
      end
      ISSUE: begin
        if (i_req_ready) begin
          reqValidD = 1'b0;
          stateD    = IDLE;
        end
      end
      default: begin
        reqValidD = 1'b0;
        stateD    = IDLE;
      end
    endcase
  end

  // Response index check is only needed when CPU_NB does not fill the index space
  if ((1 << CPU_W) == CPU_NB) begin : gRespFullRange
    assign respInRange = 1'b1;
  end else begin : gRespPartialRange
    assign respInRange = (i_resp_cpu < CPU_W'(CPU_NB));
  end

  // Responses bypass the FSM and update the addressed CPU's output vector directly
  always_comb begin
    oIrqD = oIrqQ;
    if (i_resp_valid && respInRange) begin
      oIrqD[i_resp_cpu] = i_resp_irq;
    end
  end

  // Completion is sticky once every budget is spent and no request is outstanding
  always_comb begin
    allAtBudget = ~|underBudget;
    doneD       = doneQ | (allAtBudget && (stateQ == IDLE) && !reqValidQ);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      prevQ     <= '0;
      valQ      <= '0;
      pendQ     <= '0;
      dropQ     <= '0;
      cntQ      <= '0;
      stateQ    <= IDLE;
      rrPtrQ    <= '0;
      reqValidQ <= 1'b0;
      reqCpuQ   <= '0;
      reqIrqQ   <= '0;
      oIrqQ     <= '0;
      doneQ     <= 1'b0;
    end else begin
      prevQ     <= i_irq;
      valQ      <= valD;
      pendQ     <= pendD;
      dropQ     <= dropD;
      cntQ      <= cntD;
      stateQ    <= stateD;
      rrPtrQ    <= rrPtrD;
      reqValidQ <= reqValidD;
      reqCpuQ   <= reqCpuD;
      reqIrqQ   <= reqIrqD;
      oIrqQ     <= oIrqD;
      doneQ     <= doneD;
    end
  end

  assign o_irq       = oIrqQ;
  assign o_req_valid = reqValidQ;
  assign o_req_cpu   = reqCpuQ;
  assign o_req_irq   = reqIrqQ;
  assign o_drop      = dropQ;
  assign o_done      = doneQ;

endmodule
